// File: rtl/filter_pkg.sv
// Shared filter codes for the image-filter pipeline, plus the legality check
// used wherever a filter request is accepted.
package filter_pkg;

  localparam int FILTER_W = 4;

  typedef enum logic [FILTER_W-1:0] {
    NONE      = 4'd0,
    ASCII     = 4'd2,
    POSTERIZE = 4'd3,
    MOSAIC    = 4'd4,
    INVERT    = 4'd5,
    FISHEYE   = 4'd6,
    MIRROR    = 4'd7,
    KALEIDO   = 4'd8
  } filter_code_t;

  // True for a real filter (ASCII..KALEIDO); NONE is a revert request, not a filter.
  function automatic logic is_legal_filter(input logic [FILTER_W-1:0] code);
    return (code >= ASCII) && (code <= KALEIDO);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Detects the entry into the vblank line and produces a one-cycle frame tick
// delayed by one clock from the detected edge.
module frame_tick_gen #(
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] y_pixel,
  output logic       vblank_edge,
  output logic       frame_tick
);

  localparam logic [9:0] VBLANK_LINE = 10'(V_ACTIVE);

  logic [9:0] y_prev_reg;
  logic       prev_valid_reg;
  logic       frame_tick_reg;

  // prev_valid_reg blocks a false edge when y_pixel already sits on the
  // vblank line as reset is released.
  assign vblank_edge = prev_valid_reg && (y_pixel == VBLANK_LINE) &&
                       (y_prev_reg != VBLANK_LINE);
  assign frame_tick  = frame_tick_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_prev_reg     <= '0;
      prev_valid_reg <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      y_prev_reg     <= y_pixel;
      prev_valid_reg <= 1'b1;
      frame_tick_reg <= vblank_edge;
    end
  end

endmodule

// File: rtl/filter_sel_ctrl.sv
// Filter-select controller: latches filter requests and commits them only at
// the vblank edge, with an optional frame-count hold before reverting.
module filter_sel_ctrl
  import filter_pkg::*;
#(
  parameter int          V_ACTIVE    = 480,
  parameter int          HOLD_FRAMES = 180,
  parameter logic [3:0]  DEFAULT_SEL = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       event_valid,
  input  logic [3:0] event_flag,
  input  logic [9:0] y_pixel,
  output logic [3:0] filter_sel,
  output logic       sel_pending,
  output logic       frame_tick,
  output logic [7:0] hold_left
);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    ACTIVE
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_FRAMES);

  state_t     state_reg, state_next;
  logic [3:0] pending_reg, pending_next;
  logic [3:0] sel_reg, sel_next;
  logic [7:0] hold_reg, hold_next;
  logic       vblank_edge;
  logic       event_accept;
  logic [3:0] event_code;

  frame_tick_gen #(
    .V_ACTIVE (V_ACTIVE)
  ) u_frame_tick_gen (
    .clk         (clk),
    .reset       (reset),
    .y_pixel     (y_pixel),
    .vblank_edge (vblank_edge),
    .frame_tick  (frame_tick)
  );

  // NONE is accepted as a request for the pass-through code.
  assign event_accept = event_valid &&
                        (is_legal_filter(event_flag) || (event_flag == NONE));
  assign event_code   = (event_flag == NONE) ? DEFAULT_SEL : event_flag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      sel_reg     <= DEFAULT_SEL;
      hold_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      sel_reg     <= sel_next;
      hold_reg    <= hold_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    sel_next     = sel_reg;
    hold_next    = hold_reg;

    if (vblank_edge) begin
      case (state_reg)
        PENDING: begin
          if (pending_reg != DEFAULT_SEL) begin
            state_next = ACTIVE;
            sel_next   = pending_reg;
            hold_next  = HOLD_LOAD;
          end else begin
            state_next = IDLE;
            sel_next   = DEFAULT_SEL;
            hold_next  = '0;
          end
        end
        ACTIVE: begin
          // A zero hold means the filter never times out.
          if (HOLD_LOAD != 8'd0) begin
            if (hold_reg <= 8'd1) begin
              state_next = IDLE;
              sel_next   = DEFAULT_SEL;
              hold_next  = '0;
            end else begin
              hold_next = hold_reg - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end

    // Applied after the commit so a request coinciding with the edge waits a frame.
    if (event_accept) begin
      pending_next = event_code;
      state_next   = PENDING;
    end
  end

  assign filter_sel  = sel_reg;
  assign sel_pending = (state_reg == PENDING);
  assign hold_left   = hold_reg;

endmodule

// File: tb/tb_filter_sel_ctrl.sv
// Directed bench for filter_sel_ctrl: two instances (default hold and a short
// hold) driven identically and checked every cycle against a frame-level model.
module tb_filter_sel_ctrl;

  localparam int V_ACT  = 480;
  localparam int HOLD_A = 180;
  localparam int HOLD_B = 3;

  logic       clk;
  logic       reset;
  logic       event_valid;
  logic [3:0] event_flag;
  logic [9:0] y_pixel;

  logic [3:0] sel_a, sel_b;
  logic       pend_a, pend_b, tick_a, tick_b;
  logic [7:0] hold_a, hold_b;

  logic [3:0] dsel  [2];
  logic       dpend [2];
  logic       dtick [2];
  logic [7:0] dhold [2];

  assign dsel[0]  = sel_a;   assign dsel[1]  = sel_b;
  assign dpend[0] = pend_a;  assign dpend[1] = pend_b;
  assign dtick[0] = tick_a;  assign dtick[1] = tick_b;
  assign dhold[0] = hold_a;  assign dhold[1] = hold_b;

  filter_sel_ctrl #(.V_ACTIVE(V_ACT), .HOLD_FRAMES(HOLD_A), .DEFAULT_SEL(4'd0)) dut_a (
    .clk(clk), .reset(reset), .event_valid(event_valid), .event_flag(event_flag),
    .y_pixel(y_pixel), .filter_sel(sel_a), .sel_pending(pend_a),
    .frame_tick(tick_a), .hold_left(hold_a)
  );

  filter_sel_ctrl #(.V_ACTIVE(V_ACT), .HOLD_FRAMES(HOLD_B), .DEFAULT_SEL(4'd0)) dut_b (
    .clk(clk), .reset(reset), .event_valid(event_valid), .event_flag(event_flag),
    .y_pixel(y_pixel), .filter_sel(sel_b), .sel_pending(pend_b),
    .frame_tick(tick_b), .hold_left(hold_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit seen3    = 0;

  // Model state: what is on screen, what is waiting, how long it has left.
  int hf      [2] = '{HOLD_A, HOLD_B};
  int m_sel   [2];
  int m_hold  [2];
  int m_pcode [2];
  bit m_pend  [2];
  bit m_tick  [2];
  int m_prev_y;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit accepted(input int code);
    return (code == 0) || (code >= 2 && code <= 8);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sel[i] = 0; m_hold[i] = 0; m_pcode[i] = 0; m_pend[i] = 0; m_tick[i] = 0;
    end
    m_prev_y = -1;
  endtask

  task automatic model_step();
    bit vb;
    vb = (m_prev_y >= 0) && (int'(y_pixel) == V_ACT) && (m_prev_y != V_ACT);
    for (int i = 0; i < 2; i++) begin
      m_tick[i] = vb;
      if (vb) begin
        if (m_pend[i]) begin
          m_pend[i] = 0;
          m_sel[i]  = m_pcode[i];
          m_hold[i] = (m_pcode[i] != 0) ? hf[i] : 0;
        end else if (m_sel[i] != 0 && hf[i] > 0) begin
          m_hold[i] = m_hold[i] - 1;
          if (m_hold[i] == 0) m_sel[i] = 0;
        end
      end
      if (event_valid && accepted(int'(event_flag))) begin
        m_pend[i]  = 1;
        m_pcode[i] = int'(event_flag);
      end
    end
    m_prev_y = int'(y_pixel);
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("sel[%0d]", i),  int'(dsel[i]),  m_sel[i]);
      chk($sformatf("pend[%0d]", i), int'(dpend[i]), int'(m_pend[i]));
      chk($sformatf("tick[%0d]", i), int'(dtick[i]), int'(m_tick[i]));
      chk($sformatf("hold[%0d]", i), int'(dhold[i]), m_hold[i]);
      if (dsel[i] == 4'd3) seen3 = 1;
    end
  endtask

  task automatic cyc(input bit v, input int f, input int y);
    @(negedge clk);
    event_valid = v;
    event_flag  = 4'(f);
    y_pixel     = 10'(y);
    if (v) $display("event code=%0d y=%0d t=%0t", f, y, $time);
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic line(input int y, input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, y);
  endtask

  task automatic frame();
    line(100, 2);
    cyc(0, 0, V_ACT);
    line(V_ACT, 1);
  endtask

  task automatic do_reset(input int y);
    reset       = 1'b0;
    event_valid = 1'b0;
    event_flag  = 4'd0;
    y_pixel     = 10'(y);
    $display("reset asserted y=%0d t=%0t", y, $time);
    #1;
    model_reset();
    compare_all();
    chk("rst_sel_a", int'(sel_a), 0);
    chk("rst_pend_a", int'(pend_a), 0);
    chk("rst_hold_a", int'(hold_a), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b0; event_valid = 1'b0; event_flag = 4'd0; y_pixel = 10'd0;
    model_reset();
    @(posedge clk); #1;
    // Reset released while already on the vblank line: no tick may follow.
    do_reset(V_ACT);
    line(V_ACT, 3);
    chk("no_tick_after_reset", int'(tick_a), 0);
    line(100, 1);

    // Basic request/commit.
    cyc(1, 4, 100);
    chk("req4_pend", int'(pend_a), 1);
    chk("req4_sel_before", int'(sel_a), 0);
    line(100, 2);
    chk("req4_sel_still0", int'(sel_a), 0);
    cyc(0, 0, V_ACT);
    chk("req4_sel", int'(sel_a), 4);
    chk("req4_hold_a", int'(hold_a), 180);
    chk("req4_hold_b", int'(hold_b), 3);
    chk("req4_tick", int'(tick_a), 1);
    line(V_ACT, 1);
    chk("tick_one_cycle", int'(tick_a), 0);

    // Last request in a frame wins.
    line(100, 1);
    cyc(1, 3, 100);
    cyc(1, 7, 200);
    frame();
    chk("last_wins_sel", int'(sel_a), 7);

    // Illegal codes in ACTIVE change nothing.
    cyc(1, 1, 100); cyc(1, 9, 100); cyc(1, 15, 100);
    chk("illegal_act_sel", int'(sel_a), 7);
    chk("illegal_act_pend", int'(pend_a), 0);
    chk("illegal_act_hold", int'(hold_a), 180);

    // Short hold expiry on instance b.
    cyc(1, 5, 100);
    frame();
    chk("hold3_sel", int'(sel_b), 5);
    chk("hold3_v3", int'(hold_b), 3);
    frame();
    chk("hold3_v2", int'(hold_b), 2);
    frame();
    chk("hold3_v1", int'(hold_b), 1);
    frame();
    chk("hold3_revert_sel", int'(sel_b), 0);
    chk("hold3_revert_hold", int'(hold_b), 0);
    chk("hold_a_177", int'(hold_a), 177);

    // Re-requesting the active code reloads the hold.
    cyc(1, 5, 100);
    frame();
    chk("extend_hold", int'(hold_a), 180);
    chk("extend_sel", int'(sel_a), 5);

    // Code 0 reverts to pass-through.
    cyc(1, 0, 100);
    frame();
    chk("revert_sel", int'(sel_a), 0);
    chk("revert_hold", int'(hold_a), 0);

    // Illegal codes in IDLE change nothing.
    cyc(1, 1, 100); cyc(1, 9, 100); cyc(1, 15, 100);
    chk("illegal_idle_pend", int'(pend_a), 0);
    chk("illegal_idle_sel", int'(sel_a), 0);

    // Request on the edge cycle waits a full frame.
    line(100, 2);
    cyc(1, 6, V_ACT);
    chk("edge_req_sel", int'(sel_a), 0);
    chk("edge_req_pend", int'(pend_a), 1);
    line(V_ACT, 1);
    frame();
    chk("edge_req_commit", int'(sel_a), 6);

    // Reset while pending discards the request.
    line(100, 1);
    cyc(1, 8, 100);
    #2;
    do_reset(100);
    frame();
    chk("rst_pend_sel", int'(sel_a), 0);
    chk("rst_pend_pend", int'(pend_a), 0);

    // Lines adjacent to vblank, and a request colliding with a pending commit.
    line(479, 1);
    cyc(1, 2, 479);
    cyc(1, 8, V_ACT);
    chk("collide_sel", int'(sel_a), 2);
    chk("collide_pend", int'(pend_a), 1);
    line(481, 2);
    cyc(0, 0, V_ACT);
    chk("collide_commit_a", int'(sel_a), 8);
    chk("collide_commit_b", int'(sel_b), 8);
    chk("collide_hold_b", int'(hold_b), 3);
    line(V_ACT, 1);

    chk("never_sel3", int'(seen3), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/filter_sel_ctrl.md
FILTER_SEL_CTRL -- requirements
Module: filter_sel_ctrl

Interface
REQ-001 SHALL have parameter V_ACTIVE, default 480, giving the first non-active (vblank) y_pixel line.
REQ-002 SHALL have parameter HOLD_FRAMES, default 180, giving the frames a filter stays active before auto-revert (0 = never revert, max 255).
REQ-003 SHALL have parameter DEFAULT_SEL, default 4'd0, giving the pass-through filter code.
REQ-004 SHALL have port clk, input, 1 bit: the single pixel clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port event_valid, input, 1 bit: single-cycle strobe qualifying event_flag.
REQ-007 SHALL have port event_flag, input, 4 bits: requested filter code.
REQ-008 SHALL have port y_pixel, input, 10 bits: VGA line counter.
REQ-009 SHALL have port filter_sel, output, 4 bits: registered filter code to the image filter stage.
REQ-010 SHALL have port sel_pending, output, 1 bit: a request is latched but not yet committed.
REQ-011 SHALL have port frame_tick, output, 1 bit: one-cycle pulse per frame boundary.
REQ-012 SHALL have port hold_left, output, 8 bits: remaining frames before auto-revert.

Function
REQ-013 Frame boundary (vblank edge) SHALL be the first cycle where y_pixel == V_ACTIVE and the registered previous y_pixel != V_ACTIVE; frame_tick SHALL assert in the following cycle for exactly one cycle.
REQ-014 Legal codes SHALL be 2..8; code 0 SHALL request a revert to DEFAULT_SEL; codes 1 and 9..15 SHALL be ignored, with no state change.
REQ-015 A legal event SHALL be latched into the pending register; a later event before commit SHALL overwrite it (last wins).
REQ-016 The FSM SHALL have states IDLE (filter_sel == DEFAULT_SEL), PENDING (request latched), and ACTIVE (non-default filter running).
REQ-017 IDLE -> PENDING on a legal event; PENDING -> ACTIVE at the vblank edge if pending != DEFAULT_SEL, else PENDING -> IDLE.
REQ-018 ACTIVE -> PENDING on a legal event; the current filter_sel SHALL be kept until the commit edge.
REQ-019 filter_sel SHALL change only in the cycle after a vblank edge, never during active video.
REQ-020 On commit of a non-default code, hold_left SHALL load HOLD_FRAMES.
REQ-021 In ACTIVE with HOLD_FRAMES > 0, hold_left SHALL decrement by 1 at each vblank edge.
REQ-022 When hold_left reaches 0 in ACTIVE, the FSM SHALL go to IDLE and set filter_sel = DEFAULT_SEL at that same edge.
REQ-023 An event arriving in the same cycle as a vblank edge SHALL be latched and committed at the next vblank edge, not the current one.
REQ-024 sel_pending SHALL be 1 exactly while in PENDING.
REQ-025 hold_left SHALL be 0 in IDLE, saturate at 0, and never wrap.
REQ-026 Requesting the currently active code SHALL re-commit it and reload hold_left (hold extension).

Reset
REQ-027 Asserting reset low SHALL immediately force IDLE, with filter_sel = DEFAULT_SEL, sel_pending = 0, frame_tick = 0, hold_left = 0, and the pending register and previous-y register cleared.
REQ-028 Reset mid-PENDING SHALL discard the request; no commit SHALL follow the release.
REQ-029 After reset release, the first vblank edge SHALL be detected only on a real transition into V_ACTIVE, not on a reset-time y_pixel already equal to V_ACTIVE.

Structure
REQ-030 Filter codes SHALL live in shared package filter_pkg: NONE = 0, ASCII = 2, POSTERIZE = 3, MOSAIC = 4, INVERT = 5, FISHEYE = 6, MIRROR = 7, KALEIDO = 8, together with an is_legal_filter function.
REQ-031 The FSM state enum SHALL be local to the module.
REQ-032 Vblank-edge detection SHALL be one sub-module, frame_tick_gen, instantiated once.

Verification
REQ-033 Reset, then event 4 at y = 100 -> sel_pending = 1, filter_sel = 0 until the cycle after y enters 480, then filter_sel = 4 and hold_left = 180.
REQ-034 Events 3 then 7 within one frame -> a single commit with filter_sel = 7; 3 never appears on filter_sel.
REQ-035 HOLD_FRAMES = 3, commit 5 -> hold_left reads 3, 2, 1 over successive ticks, and filter_sel returns to 0 at the 3rd tick after commit.
REQ-036 Event 6 in the same cycle as a vblank edge -> no change at that edge; filter_sel = 6 one frame later.
REQ-037 Events 1, 9, and 15 in IDLE and ACTIVE -> state, filter_sel, and hold_left unchanged.
REQ-038 reset pulsed low during PENDING with event 8 -> outputs reset immediately; the next vblank edge leaves filter_sel = 0.
